fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the architectural fetch PC register.
- Drives the current PC to the next-PC generator and takes its `pc_next` result back.
- Issues in-order requests to instruction memory and pairs each response with its PC.
- Buffers fetched words for decode; on a jump or CSR redirect, flushes the buffer and in-flight fetches.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a shared
// credit budget and buffers returned words for decode. Optional: IFETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_8000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        inst_misaligned
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   r_pc;
  logic          r_run;
  logic [CW-1:0] r_if_cnt, r_buf_cnt, r_drop_cnt;
  logic [PW-1:0] r_if_wr, r_if_rd, r_buf_wr, r_buf_rd;
  logic [31:0]   r_if_pc    [BUF_DEPTH];
  logic [31:0]   r_buf_pc   [BUF_DEPTH];
  logic [31:0]   r_buf_data [BUF_DEPTH];

  logic [SW-1:0] w_sum;
  logic          w_credit, w_fetch_ok, w_mis_push;
  logic          w_req_fire, w_resp_take, w_resp_drop, w_push, w_pop;
  logic [31:0]   w_push_pc, w_push_data;

  // Drops still count against the budget: their responses have not arrived yet.
  assign w_sum    = SW'(r_if_cnt) + SW'(r_buf_cnt) + SW'(r_drop_cnt);
  assign w_credit = (w_sum < SW'(BUF_DEPTH));

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_stall;
  logic r_buf_mis [BUF_DEPTH];
  logic w_misal;

  assign w_misal    = (r_pc[1:0] != 2'b00);
  assign w_fetch_ok = !w_misal && !r_stall;
  assign w_mis_push = r_run && !redirect && w_credit && w_misal && !r_stall && (r_if_cnt == '0);
  assign inst_misaligned = r_buf_mis[r_buf_rd];

  always_ff @(posedge clk) begin
    if (!rstn)         r_stall <= 1'b0;
    else if (redirect) r_stall <= 1'b0;
    else if (w_mis_push) r_stall <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf_mis[r_buf_wr] <= w_mis_push;
  end
`else
  assign w_fetch_ok = 1'b1;
  assign w_mis_push = 1'b0;
`endif

  assign pc             = r_pc;
  assign imem_req_addr  = {r_pc[31:2], 2'b00};
  assign imem_req_valid = r_run && !redirect && w_credit && w_fetch_ok;

  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_resp_take = imem_resp_valid && (r_drop_cnt == '0);
  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  assign w_push      = w_resp_take || w_mis_push;
  assign w_pop       = inst_valid && inst_ready;

  assign w_push_pc   = w_mis_push ? r_pc  : r_if_pc[r_if_rd];
  assign w_push_data = w_mis_push ? '0    : imem_resp_data;

  assign inst_valid = (r_buf_cnt != '0);
  assign inst_data  = r_buf_data[r_buf_rd];
  assign inst_pc    = r_buf_pc[r_buf_rd];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_run      <= 1'b0;
      r_if_cnt   <= '0;
      r_buf_cnt  <= '0;
      r_drop_cnt <= '0;
      r_if_wr    <= '0;
      r_if_rd    <= '0;
      r_buf_wr   <= '0;
      r_buf_rd   <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect) begin
        // Everything outstanding becomes a drop, minus the response landing right now.
        r_pc       <= pc_next;
        r_drop_cnt <= r_drop_cnt + r_if_cnt - CW'(imem_resp_valid);
        r_if_cnt   <= '0;
        r_if_wr    <= '0;
        r_if_rd    <= '0;
        r_buf_cnt  <= '0;
        r_buf_wr   <= '0;
        r_buf_rd   <= '0;
      end else begin
        if (w_req_fire)  r_pc       <= pc_next;
        if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_req_fire)  r_if_wr    <= ptr_inc(r_if_wr);
        if (w_resp_take) r_if_rd    <= ptr_inc(r_if_rd);
        if (w_push)      r_buf_wr   <= ptr_inc(r_buf_wr);
        if (w_pop)       r_buf_rd   <= ptr_inc(r_buf_rd);
        r_if_cnt  <= r_if_cnt + CW'(w_req_fire) - CW'(w_resp_take);
        r_buf_cnt <= r_buf_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_if_pc[r_if_wr] <= r_pc;
    if (w_push) begin
      r_buf_pc[r_buf_wr]   <= w_push_pc;
      r_buf_data[r_buf_wr] <= w_push_data;
    end
  end

  always @(posedge clk) begin
    if (rstn) assert (w_sum <= SW'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for free-run/backpressure, hand sequences for
// redirects, random request-ready throttling and (if enabled) the misalignment trap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        imem_req_ready = 1'b1;
  logic        inst_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        mem_hold = 1'b0;
  logic [31:0] pc, pc_next, imem_req_addr, inst_data, inst_pc;
  logic        imem_req_valid, inst_valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        inst_misaligned;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mq[$];
  logic [31:0] ma;

  always #5 clk = ~clk;

  assign pc_next = redirect ? tgt : pc + 32'd4;

  fetch_unit #(.RESET_PC(32'h0000_8000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .pc_next(pc_next), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    , .inst_misaligned(inst_misaligned)
`endif
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // In-order memory: response visible the cycle after the accepting edge unless held.
  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
      if (!mem_hold && mq.size() > 0) begin
        ma = mq.pop_front();
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= mdata(ma);
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; redirect = 1'b0; mem_hold = 1'b0; imem_req_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_data);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!inst_valid && n < 20);
    if (!inst_valid) begin
      checks++; errors++;
      $display("FAIL %s: no instruction within 20 cycles, expected pc %h", name, exp_pc);
    end else begin
      chk({name, "_pc"}, inst_pc, exp_pc);
      chk({name, "_data"}, inst_data, exp_data);
    end
  endtask

  typedef struct {
    logic        rst_before;
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_req, exp_inst;
    int got;

    // Free-running from reset (c0 = cycle after the last reset edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h8000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h8000, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h8004, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h8008, 1'b1, 32'h8000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h8008, 1'b1, 32'h8004};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h800C, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h8010, 1'b1, 32'h8008};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h8010, 1'b1, 32'h800C};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h8014, 1'b0, 32'h0};
    // Decode stalled for 10 cycles, then released
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h8000, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h8000, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h8004, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h8008, 1'b1, 32'h8000};
    for (int i = 13; i <= 18; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 32'h8008, 1'b1, 32'h8000};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 32'h8008, 1'b1, 32'h8000};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 32'h8008, 1'b1, 32'h8004};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 32'h800C, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 32'h8010, 1'b1, 32'h8008};

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].rst_before) do_reset();
      else @(negedge clk);
      inst_ready = tbl[i].rdy;
      #1;
      chk1($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].exp_addr);
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk1($sformatf("v%0d_inst_valid", i), inst_valid, tbl[i].exp_iv);
      if (tbl[i].exp_iv) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].exp_ipc);
        chk($sformatf("v%0d_inst_data", i), inst_data, mdata(tbl[i].exp_ipc));
      end
    end

    // Redirect with two requests in flight: both responses must be dropped
    do_reset();
    inst_ready = 1'b1; mem_hold = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    chk1("rd2_full_credit", imem_req_valid, 1'b0);
    redirect = 1'b1; tgt = 32'h9000; mem_hold = 1'b0;
    #1;
    chk1("rd2_no_req_in_redirect", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("rd2_pc", pc, 32'h9000);
    chk1("rd2_buf_empty", inst_valid, 1'b0);
    chk1("rd2_drops_hold_credit", imem_req_valid, 1'b0);
    wait_inst("rd2_first", 32'h9000, mdata(32'h9000));
    wait_inst("rd2_second", 32'h9004, mdata(32'h9004));

    // Redirect coinciding with a response and a decode pop
    do_reset();
    inst_ready = 1'b0; mem_hold = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_hold = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk1("rdp_pre_valid", inst_valid, 1'b1);
    chk("rdp_pre_pc", inst_pc, 32'h8000);
    inst_ready = 1'b1; redirect = 1'b1; tgt = 32'h9000;
    #1;
    chk1("rdp_no_req_in_redirect", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk1("rdp_buf_empty", inst_valid, 1'b0);
    chk("rdp_pc", pc, 32'h9000);
    chk1("rdp_req_valid", imem_req_valid, 1'b1);
    chk("rdp_req_addr", imem_req_addr, 32'h9000);
    wait_inst("rdp_i0", 32'h9000, mdata(32'h9000));
    wait_inst("rdp_i1", 32'h9004, mdata(32'h9004));
    wait_inst("rdp_i2", 32'h9008, mdata(32'h9008));

    // Randomly throttled request-ready over 100 instructions
    do_reset();
    inst_ready = 1'b1;
    exp_req = 32'h8000; exp_inst = 32'h8000; got = 0;
    for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
      @(negedge clk);
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_req_addr", imem_req_addr, exp_req);
        exp_req += 32'd4;
      end
      if (inst_valid) begin
        chk("rnd_inst_pc", inst_pc, exp_inst);
        chk("rnd_inst_data", inst_data, mdata(exp_inst));
        exp_inst += 32'd4;
        got++;
      end
    end
    if (got < 100) begin
      checks++; errors++;
      $display("FAIL rnd_count: got %0d instructions expected 100", got);
    end
    imem_req_ready = 1'b1;

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned redirect target traps once, then fetch stalls until the next redirect
    do_reset();
    inst_ready = 1'b1; redirect = 1'b1; tgt = 32'h9002;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("mis_pc", pc, 32'h9002);
    chk1("mis_no_req", imem_req_valid, 1'b0);
    wait_inst("mis_entry", 32'h9002, 32'h0);
    chk1("mis_flag", inst_misaligned, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk1($sformatf("mis_stall_rv%0d", k), imem_req_valid, 1'b0);
      chk1($sformatf("mis_stall_iv%0d", k), inst_valid, 1'b0);
    end
    redirect = 1'b1; tgt = 32'h9100;
    @(negedge clk);
    redirect = 1'b0;
    wait_inst("mis_resume", 32'h9100, mdata(32'h9100));
    chk1("mis_resume_flag", inst_misaligned, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
